// File: rtl/shr32_pkg.sv
// Shared definitions for the shared 32-bit truncated right-shifter arbiter.
package shr32_pkg;

    localparam int SHR_W   = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/G_TRShifter32.sv
// Gate-level 32-bit truncated logical right shifter: five log-stages of 2:1 muxes,
// bits shifted past bit 0 are dropped and zeros fill from the top.
module G_TRShifter32
    import shr32_pkg::*;
(
    input  logic [SHR_W-1:0]   In1,
    input  logic [SHAMT_W-1:0] In2,
    output logic [SHR_W-1:0]   Out
);

    logic [SHAMT_W:0][SHR_W-1:0] stage;

    assign stage[0] = In1;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int DIST = 1 << k;
        for (genvar i = 0; i < SHR_W; i++) begin : g_bit
            if (i + DIST < SHR_W) begin : g_mux
                assign stage[k+1][i] = (In2[k] & stage[k][i+DIST]) | (~In2[k] & stage[k][i]);
            end else begin : g_zero
                // Source bit lies above the MSB: a selected shift pulls in zero.
                assign stage[k+1][i] = ~In2[k] & stage[k][i];
            end
        end
    end

    assign Out = stage[SHAMT_W];

endmodule

// File: rtl/shr32_arbiter.sv
// Two-requester round-robin arbiter sharing one G_TRShifter32; each operation is
// registered, shifted in EXEC, and presented in DONE with the issuing requester's ID.
module shr32_arbiter
    import shr32_pkg::*;
#(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [SHR_W-1:0]   req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [SHR_W-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               req1_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SHR_W-1:0]   res_data,
    output logic               res_id,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    state_t               state_q, state_d;
    logic                 last_grant_q;
    logic [SHR_W-1:0]     opa_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic                 id_q;
    logic                 grant0, grant1, accept;
    logic [SHR_W-1:0]     shift_out;

    // A lone requester always wins; under contention the one not granted last time wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    assign accept = (state_q == IDLE) & (grant0 | grant1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the default assignment before the case keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        res_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q        <= '0;
            shamt_q      <= '0;
            id_q         <= 1'b0;
            last_grant_q <= ~PRIO_INIT;
        end else if (accept) begin
            opa_q        <= grant1 ? req1_data  : req0_data;
            shamt_q      <= grant1 ? req1_shamt : req0_shamt;
            id_q         <= grant1;
            last_grant_q <= grant1;
        end
    end

    G_TRShifter32 u_shifter (
        .In1 (opa_q),
        .In2 (shamt_q),
        .Out (shift_out)
    );

    // Result registers only load in EXEC, so they stay frozen through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_id   <= 1'b0;
        end else if (state_q == EXEC) begin
            res_data <= shift_out;
            res_id   <= id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               op_count <= '0;
        else if ((state_q == DONE) && res_ready)  op_count <= op_count + 1'b1;
    end

endmodule

// File: doc/shr32_arbiter.md
# shr32_arbiter

Shares one gate-level 32-bit truncated logical right shifter (`G_TRShifter32`) between two requesters over valid/ready handshakes. Each granted operation is registered, shifted, and returned with the requester's ID. The block sits between the ALU32 issue logic and the shift datapath. It replaces direct combinational hookup when two sources (ALU path and address-generation path) need the shifter.

## Interface
- `PRIO_INIT`, default 0: requester that wins the first simultaneous contention after reset.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_data`  in  32  operand to shift.
- `req0_shamt`  in  5  shift amount 0..31.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req1_valid`, `req1_data`, `req1_shamt`, `req1_ready`: same as requester 0.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  32  `data >> shamt`, zero-filled.
- `res_id`  out  1  requester that issued the result.
- `busy`  out  1  state != IDLE.
- `op_count`  out  16  completed results; wraps.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not in `last_grant`.
  - `reqX_ready = (state==IDLE) & grantX`. It is combinational from valid; valid never depends on ready.
  - On accept: latch `data`, `shamt` and the ID into operand registers; update `last_grant`; go to EXEC.
- EXEC:
  - Operand registers drive the shifter.
  - Next edge: capture shifter output into `res_data`, ID into `res_id`; go to DONE.
- DONE:
  - `res_valid=1`.
  - `res_data` and `res_id` are held stable until `res_ready`.
  - On `res_valid & res_ready`: increment `op_count` (0xFFFF→0x0000); go to IDLE.
- Both `reqX_ready` are 0 in EXEC and DONE. Requesters hold valid and payload until ready.
- Shift rule:
  - `res_data = data >> shamt`, logical, zero-fill.
  - shamt 0 gives pass-through.
  - No shift ≥32 is possible (5-bit field).
- A requester dropping valid while not granted has no effect; no state is held per requester.

## Timing
- Accept at edge N. State is EXEC in cycle N+1. `res_valid=1` from cycle N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, DONE with `res_ready=1`. The next accept is possible in the cycle after the DONE handshake.
- Reset values (asynchronous on `rst_n` low, held while low):
  - state=IDLE, `res_valid=0`, `res_data=0`, `res_id=0`.
  - `op_count=0`, `busy=0`, operand registers 0.
  - `last_grant=~PRIO_INIT`.
- Reset in EXEC or DONE discards the in-flight operation; no result is produced after release.
- First cycle after `rst_n` rises: IDLE. Acceptance is possible that cycle.
- `res_ready` asserted in IDLE or EXEC is ignored.

## Structure
- Shared package `shr32_pkg`:
  - state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - `SHR_W=32`, `SHAMT_W=5`, `CNT_W=16`.
- Sub-module: one instance of `G_TRShifter32` (In1 = operand register, In2 = shamt register).
- Round-robin grant logic is in-line; no separate module.

## Test plan
- Req0 only, data 0x80000000, shamt 31 → `req0_ready` at N; `res_valid` at N+2; `res_data`=0x00000001, `res_id`=0; `op_count`=1 after handshake.
- Req0 and req1 both continuously valid, `res_ready`=1, PRIO_INIT=0 → `res_id` sequence 0,1,0,1; one result per 3 cycles.
- Req1 data 0xDEADBEEF shamt 0, `res_ready` low 5 cycles → `res_data`=0xDEADBEEF stable; `res_valid` held; both readies 0 until handshake.
- Req0 data 0xF0F0F0F0 shamt 4, `rst_n` pulsed low during EXEC → all outputs return to reset values immediately; no `res_valid` after release.
- Preload 0xFFFF completions, then one more → `op_count` wraps to 0x0000.
- Req1 valid alone, then both valid next op with `last_grant`=1 → req0 wins the contention.
